// File: rtl/ddr3_wb_traffic_gen.sv
// ddr3_wb_traffic_gen: Wishbone pipelined memory exerciser for the DDR3
// controller. Writes an address-derived pattern, reads it back, checks it.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_start launches a
// test; o_busy/o_done/o_pass/o_err_count/o_first_err_addr/o_proto_err report
// status; o_wb_* / i_wb_* form the pipelined Wishbone master interface.
module ddr3_wb_traffic_gen #(
   parameter int          ADDR_W          = 24,
   parameter int          DATA_W          = 512,
   parameter int          START_ADDR      = 0,
   parameter int          NUM_WORDS       = 1024,
   parameter logic [31:0] SEED            = 32'h0,
   parameter int          MAX_OUTSTANDING = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_pass,
   output logic [15:0]           o_err_count,
   output logic [ADDR_W-1:0]     o_first_err_addr,
   output logic                  o_proto_err,
   output logic                  o_wb_cyc,
   output logic                  o_wb_stb,
   output logic                  o_wb_we,
   output logic [ADDR_W-1:0]     o_wb_addr,
   output logic [DATA_W-1:0]     o_wb_data,
   output logic [DATA_W/8-1:0]   o_wb_sel,
   input  logic                  i_wb_stall,
   input  logic                  i_wb_ack,
   input  logic [DATA_W-1:0]     i_wb_data
);

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_WDRAIN, S_READ, S_RDRAIN, S_DONE
   } state_t;

   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [OW-1:0] MAXO = OW'(MAX_OUTSTANDING);
   localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(START_ADDR);
   localparam logic [ADDR_W-1:0] LAST =
      ADDR_W'(START_ADDR + NUM_WORDS - 1);

   function automatic logic [DATA_W-1:0] pattern(
      input logic [ADDR_W-1:0] a
   );
      logic [31:0] base;
      pattern = '0;
      base = SEED ^ 32'(a);
      for (int k = 0; k < DATA_W / 32; k++)
         pattern[k*32 +: 32] = base + 32'(k);
   endfunction

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] chk_q, chk_d;
   logic [OW-1:0]     out_q, out_d;
   logic [15:0]       err_q, err_d;
   logic [ADDR_W-1:0] first_q, first_d;
   logic              proto_q, proto_d;

   logic issuing, stb, accept, ack_ok, rd_ack, mismatch;

   assign issuing = (state_q == S_WRITE) || (state_q == S_READ);
   // An ack in the same cycle frees a slot, so a full window may still issue.
   assign stb     = issuing && ((out_q != MAXO) || i_wb_ack);
   assign accept  = stb && !i_wb_stall;
   assign ack_ok  = i_wb_ack && (out_q != '0);
   assign rd_ack  = ack_ok &&
                    ((state_q == S_READ) || (state_q == S_RDRAIN));
   assign mismatch = rd_ack && (i_wb_data != pattern(chk_q));

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      chk_d   = chk_q;
      err_d   = err_q;
      first_d = first_q;
      proto_d = proto_q;
      out_d   = out_q;

      case ({accept, ack_ok})
         2'b10:   out_d = out_q + OW'(1);
         2'b01:   out_d = out_q - OW'(1);
         default: out_d = out_q;
      endcase

      if (i_wb_ack && (out_q == '0))
         proto_d = 1'b1;

      if (rd_ack)
         chk_d = chk_q + ADDR_W'(1);

      if (mismatch) begin
         if (err_q == '0)
            first_d = chk_q;
         if (err_q != 16'hFFFF)
            err_d = err_q + 16'd1;
      end

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               state_d = S_WRITE;
               addr_d  = FIRST;
               chk_d   = FIRST;
               err_d   = '0;
               first_d = '0;
               proto_d = 1'b0;
            end
         end
         S_WRITE, S_READ: begin
            if (accept) begin
               if (addr_q == LAST) begin
                  addr_d  = FIRST;
                  state_d = (state_q == S_WRITE) ? S_WDRAIN : S_RDRAIN;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
         S_WDRAIN: begin
            if (out_q == '0)
               state_d = S_READ;
         end
         S_RDRAIN: begin
            // Look at the post-ack count so the final ack finishes next cycle.
            if (out_d == '0)
               state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= FIRST;
         chk_q   <= FIRST;
         out_q   <= '0;
         err_q   <= '0;
         first_q <= '0;
         proto_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         chk_q   <= chk_d;
         out_q   <= out_d;
         err_q   <= err_d;
         first_q <= first_d;
         proto_q <= proto_d;
      end
   end

   assign o_wb_cyc  = (state_q == S_WRITE) || (state_q == S_WDRAIN) ||
                      (state_q == S_READ)  || (state_q == S_RDRAIN);
   assign o_busy    = o_wb_cyc;
   assign o_wb_stb  = stb;
   assign o_wb_we   = (state_q == S_WRITE);
   assign o_wb_addr = issuing ? addr_q : '0;
   assign o_wb_data = (state_q == S_WRITE) ? pattern(addr_q) : '0;
   assign o_wb_sel  = '1;

   assign o_done           = (state_q == S_DONE);
   assign o_pass           = o_done && (err_q == '0) && !proto_q;
   assign o_err_count      = err_q;
   assign o_first_err_addr = first_q;
   assign o_proto_err      = proto_q;

endmodule

// File: tb/tb_ddr3_wb_traffic_gen.sv
// tb_ddr3_wb_traffic_gen: bench for the Wishbone DDR3 traffic generator.
// Slave model with latency/stall/corruption, transaction scoreboard.
module tb_ddr3_wb_traffic_gen;

   localparam int AW   = 24;
   localparam int DW   = 64;
   localparam int NW   = 4;
   localparam int MAXO = 2;
   localparam logic [AW-1:0] SA = 24'h10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic i_start = 1'b0;
   logic stall = 1'b0;
   logic ack = 1'b0;
   logic [DW-1:0] rdata = '0;

   logic          o_busy, o_done, o_pass, o_proto_err;
   logic [15:0]   o_err_count;
   logic [AW-1:0] o_first_err_addr, o_wb_addr;
   logic          o_wb_cyc, o_wb_stb, o_wb_we;
   logic [DW-1:0] o_wb_data;
   logic [DW/8-1:0] o_wb_sel;

   ddr3_wb_traffic_gen #(
      .ADDR_W(AW), .DATA_W(DW), .START_ADDR(16), .NUM_WORDS(NW),
      .SEED(32'h0), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start),
      .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
      .o_err_count(o_err_count), .o_first_err_addr(o_first_err_addr),
      .o_proto_err(o_proto_err),
      .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
      .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
      .i_wb_stall(stall), .i_wb_ack(ack), .i_wb_data(rdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   typedef struct {
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } txn_t;

   typedef struct {
      bit            we;
      logic [AW-1:0] addr;
      int            due;
   } pend_t;

   txn_t  exp_q[$];
   pend_t pend[$];
   logic [DW-1:0] mem [logic [AW-1:0]];

   int lat = 0;
   int stall_left = 0;
   int cyc = 0;
   int wr_acc = 0;
   int rd_acc = 0;
   int last_ack_cyc = 0;
   int max_out = 0;
   bit bad_en = 1'b0;
   bit spur = 1'b0;
   bit prev_st = 1'b0;
   logic [AW-1:0] hold_a;
   logic [DW-1:0] hold_d;

   // Independent pattern model: two 32-bit lanes, seed 0.
   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      logic [31:0] b;
      b = {8'h00, a};
      return {b + 32'd1, b};
   endfunction

   function automatic logic [DW-1:0] rd_mem(input logic [AW-1:0] a);
      logic [DW-1:0] v;
      v = mem.exists(a) ? mem[a] : '0;
      if (bad_en && a == SA + 24'd2)
         v[0] = ~v[0];
      return v;
   endfunction

   // Slave model: drives inputs on the falling edge.
   always @(negedge clk) begin
      pend_t p;
      txn_t  t;
      int    ob;
      bit    ack_now;
      if (!rst_n) begin
         ack = 1'b0;
         stall = 1'b0;
         rdata = '0;
         prev_st = 1'b0;
         pend.delete();
      end else begin
         cyc++;
         ob = pend.size();
         ack_now = (ob > 0) && (pend[0].due == cyc);
         rdata = '0;
         if (ack_now) begin
            p = pend.pop_front();
            if (!p.we) begin
               rdata = rd_mem(p.addr);
               last_ack_cyc = cyc;
            end
         end
         ack = ack_now || spur;
         stall = 1'b0;
         #1;
         if (prev_st) begin
            check("hold_addr", 64'(o_wb_addr), 64'(hold_a));
            check("hold_data", o_wb_data, hold_d);
         end
         if (o_wb_stb && o_wb_we && o_wb_addr == SA + 24'd1 &&
             stall_left > 0) begin
            stall = 1'b1;
            stall_left--;
         end
         prev_st = stall && o_wb_stb;
         hold_a = o_wb_addr;
         hold_d = o_wb_data;
         if (ob >= MAXO && !ack)
            check("stb_full", 64'(o_wb_stb), 64'd0);
         if (o_wb_stb && !stall) begin
            if (exp_q.size() == 0) begin
               check("extra_accept", 64'd1, 64'd0);
            end else begin
               t = exp_q.pop_front();
               check("acc_we", 64'(o_wb_we), 64'(t.we));
               check("acc_addr", 64'(o_wb_addr), 64'(t.addr));
               if (t.we)
                  check("acc_data", o_wb_data, t.data);
            end
            if (o_wb_we) begin
               mem[o_wb_addr] = o_wb_data;
               wr_acc++;
            end else begin
               rd_acc++;
            end
            pend.push_back('{o_wb_we, o_wb_addr, cyc + 1 + lat});
         end
         if (pend.size() > max_out)
            max_out = pend.size();
      end
   end

   task automatic chk_reset();
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_done", 64'(o_done), 64'd0);
      check("rst_pass", 64'(o_pass), 64'd0);
      check("rst_err", 64'(o_err_count), 64'd0);
      check("rst_first", 64'(o_first_err_addr), 64'd0);
      check("rst_proto", 64'(o_proto_err), 64'd0);
      check("rst_cyc", 64'(o_wb_cyc), 64'd0);
      check("rst_stb", 64'(o_wb_stb), 64'd0);
      check("rst_we", 64'(o_wb_we), 64'd0);
      check("rst_addr", 64'(o_wb_addr), 64'd0);
      check("rst_data", o_wb_data, 64'd0);
      check("rst_sel", 64'(o_wb_sel), 64'hFF);
   endtask

   task automatic load_exp();
      exp_q.delete();
      for (int i = 0; i < NW; i++)
         exp_q.push_back('{1'b1, SA + AW'(i), pat(SA + AW'(i))});
      for (int i = 0; i < NW; i++)
         exp_q.push_back('{1'b0, SA + AW'(i), '0});
   endtask

   task automatic pulse_start(input bit first_chk);
      @(posedge clk);
      #2 i_start = 1'b1;
      @(posedge clk);
      #1;
      if (first_chk) begin
         check("t1_busy", 64'(o_busy), 64'd1);
         check("t1_stb", 64'(o_wb_stb), 64'd1);
         check("t1_we", 64'(o_wb_we), 64'd1);
         check("t1_addr", 64'(o_wb_addr), 64'(SA));
      end
      #1 i_start = 1'b0;
   endtask

   task automatic run_test(input int l, input bit bad, input int st,
                           input bit exp_pass, input int exp_err,
                           input logic [AW-1:0] exp_first,
                           input bit first_chk);
      int n;
      lat = l;
      bad_en = bad;
      stall_left = st;
      wr_acc = 0;
      rd_acc = 0;
      max_out = 0;
      mem.delete();
      load_exp();
      pulse_start(first_chk);
      n = 0;
      while (!o_done && n < 600) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!o_done) begin
         check("timeout", 64'd0, 64'd1);
      end else begin
         check("done_lat", 64'(cyc), 64'(last_ack_cyc));
         check("pass", 64'(o_pass), 64'(exp_pass));
         check("err_count", 64'(o_err_count), 64'(exp_err));
         check("first_err", 64'(o_first_err_addr), 64'(exp_first));
         check("proto", 64'(o_proto_err), 64'd0);
         check("busy_end", 64'(o_busy), 64'd0);
         check("cyc_end", 64'(o_wb_cyc), 64'd0);
         check("wr_accepts", 64'(wr_acc), 64'(NW));
         check("rd_accepts", 64'(rd_acc), 64'(NW));
         check("sb_left", 64'(exp_q.size()), 64'd0);
      end
   endtask

   initial begin
      int n;
      #12;
      chk_reset();
      #11 rst_n = 1'b1;

      // ideal slave, back-to-back
      run_test(0, 1'b0, 0, 1'b1, 0, '0, 1'b1);
      check("mem_0x11", mem[SA + 24'd1], 64'h00000012_00000011);
      check("mem_0x13", mem[SA + 24'd3], 64'h00000014_00000013);

      // corrupted read at 0x12
      run_test(0, 1'b1, 0, 1'b0, 1, SA + 24'd2, 1'b0);

      // 5-cycle stall on the write of 0x11
      run_test(0, 1'b0, 5, 1'b1, 0, '0, 1'b0);
      check("stall_used", 64'(stall_left), 64'd0);

      // slow acks, window of two
      run_test(10, 1'b0, 0, 1'b1, 0, '0, 1'b0);
      check("max_out", 64'(max_out), 64'(MAXO));

      // reset in the middle of the read phase
      lat = 3;
      bad_en = 1'b0;
      stall_left = 0;
      mem.delete();
      load_exp();
      pulse_start(1'b0);
      n = 0;
      while (!(o_wb_stb && !o_wb_we) && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("saw_read", 64'(o_wb_stb && !o_wb_we), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      chk_reset();
      exp_q.delete();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // stray ack while idle
      @(posedge clk);
      #2 spur = 1'b1;
      @(posedge clk);
      #2 spur = 1'b0;
      @(posedge clk);
      #1;
      check("spur_proto", 64'(o_proto_err), 64'd1);
      check("spur_busy", 64'(o_busy), 64'd0);

      // fresh start clears the flag and passes
      run_test(0, 1'b0, 0, 1'b1, 0, '0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ddr3_wb_traffic_gen.md
# ddr3_wb_traffic_gen

Wishbone pipelined bus master that drives the DDR3 controller's Wishbone slave port as a built-in memory exerciser. On a start pulse it writes a deterministic address-derived pattern over a configurable word range, then reads the same range back and compares each returned word against the expected pattern. It reports pass/fail, an error count and the first failing address. It sits between the board-level test logic and the controller, in place of the user bus.

## Interface
Parameters:
- ADDR_W, 24: Wishbone word-address width; must match the controller's word-address width.
- DATA_W, 512: Wishbone data width; multiple of 32.
- START_ADDR, 0: first word address exercised.
- NUM_WORDS, 1024: number of words exercised; valid range 1 .. 2^ADDR_W − START_ADDR.
- SEED, 32'h0: pattern seed.
- MAX_OUTSTANDING, 16: maximum number of accepted but unacknowledged requests.

Ports:
- i_clk, in, 1: controller clock.
- i_rst_n, in, 1: asynchronous active-low reset.
- i_start, in, 1: start pulse; ignored while o_busy=1.
- o_busy, out, 1: a test is in progress.
- o_done, out, 1: test complete; held until the next accepted i_start.
- o_pass, out, 1: valid while o_done=1; equals (o_err_count==0 && !o_proto_err).
- o_err_count, out, 16: number of mismatched read words; saturates at 16'hFFFF.
- o_first_err_addr, out, ADDR_W: address of the first mismatching word.
- o_proto_err, out, 1: sticky flag; set by an ack received with zero requests outstanding.
- o_wb_cyc, o_wb_stb, o_wb_we, out, 1 each: Wishbone master controls.
- o_wb_addr, out, ADDR_W: request address.
- o_wb_data, out, DATA_W: write data.
- o_wb_sel, out, DATA_W/8: byte enables; constant all-ones.
- i_wb_stall, i_wb_ack, in, 1 each: Wishbone slave responses.
- i_wb_data, in, DATA_W: read data.

## Operation
- Pattern: for word address a, 32-bit lane k (k=0 is LSB lane) = (SEED ^ zero-extend(a) to 32 bits) + k, modulo 2^32.
- FSM states: IDLE, WRITE, WDRAIN, READ, RDRAIN, DONE.
  - IDLE/DONE: on i_start, clear counters, flags, o_done and o_first_err_addr, then go to WRITE.
  - WRITE: issue NUM_WORDS write requests at ascending addresses from START_ADDR. After the last request is accepted, go to WDRAIN.
  - WDRAIN: wait until outstanding==0, then go to READ.
  - READ: issue NUM_WORDS read requests at ascending addresses. After the last request is accepted, go to RDRAIN.
  - RDRAIN: wait until outstanding==0, then go to DONE.
- A request is accepted in a cycle where o_wb_stb && !i_wb_stall.
  - o_wb_addr, o_wb_we and o_wb_data are held stable while stalled.
  - After an accept, the next address is presented on the following cycle.
- Outstanding counter:
  - +1 on accept; −1 on ack; unchanged when both occur in the same cycle.
  - o_wb_stb is low whenever outstanding==MAX_OUTSTANDING and no ack is present in that cycle.
- Read check:
  - Acks return in order. A read-check address counter starts at START_ADDR and increments on each read ack.
  - Each read ack compares i_wb_data with pattern(check address). On mismatch: o_err_count increments (saturating), and the address is captured into o_first_err_addr if this is the first error.
- Write acks only decrement the outstanding counter; their data is ignored.
- Ack with outstanding==0: set o_proto_err and do not decrement (no underflow).
- o_wb_cyc is high in WRITE, WDRAIN, READ and RDRAIN; low in IDLE and DONE.
- Reset (any time, including mid-test):
  - All outputs are 0 except o_wb_sel, which is all-ones.
  - FSM returns to IDLE and the outstanding counter returns to 0.
  - Acks arriving after reset release while in IDLE set o_proto_err.

## Timing
- i_start sampled at cycle t: o_busy=1 and o_wb_stb=1 (we=1, addr=START_ADDR) at t+1.
- With no stall and ack latency 0 (ack in the cycle after accept), one request is accepted per cycle with no bubbles.
- WDRAIN → READ transition: the first read stb is asserted the cycle after outstanding reaches 0.
- The final read ack in cycle t produces, at t+1: o_done=1, o_busy=0, o_err_count and o_pass final.
- Address arithmetic is ADDR_W bits wide and must not wrap; the parameter range guarantees this.

## Test plan
- NUM_WORDS=4, START_ADDR=0x10, SEED=0, ideal slave model → writes to 0x10..0x13, lane k of word 0x11 = 0x11+k. Reads return the stored data → o_done=1, o_pass=1, o_err_count=0.
- Same setup, slave corrupts bit 0 of the read at 0x12 → o_err_count=1, o_first_err_addr=0x12, o_pass=0.
- i_wb_stall high for 5 cycles during the write of 0x11 → addr and data are held stable for all 5 cycles; exactly 4 writes are accepted and there are no duplicate accepts.
- MAX_OUTSTANDING=2, acks delayed 10 cycles → stb drops whenever outstanding==2; the outstanding counter never exceeds 2; the test still passes.
- Spurious ack while in IDLE → o_proto_err=1. A subsequent i_start clears the flag and the test passes.
- i_rst_n asserted mid-READ → all outputs are at reset values immediately and o_wb_cyc=0. A fresh i_start completes with o_pass=1.
